// File: rtl/mod_idex_operand_stage_pkg.sv
// Shared MIPS core definitions: datapath widths, the zero register and forwarding selects.
package mips_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned RADDR_W = 5;

    // $0 is hard-wired to zero and must never be a forwarding source.
    localparam logic [RADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/mod_idex_operand_stage_if.sv
// ID/EX operand-stage bus: decoded ID fields, forwarding sources, and EX-side results.
interface mod_idex_operand_stage_if import mips_pkg::*; #(
    parameter int unsigned DATA_W  = mips_pkg::DATA_W,
    parameter int unsigned RADDR_W = mips_pkg::RADDR_W,
    parameter int unsigned CNT_W   = 16
) ();

    // Decoded instruction in ID
    logic               id_valid;
    logic [RADDR_W-1:0] id_rs1_addr;
    logic [RADDR_W-1:0] id_rs2_addr;
    logic [RADDR_W-1:0] id_rd_addr;
    logic [DATA_W-1:0]  id_rs1_data;
    logic [DATA_W-1:0]  id_rs2_data;
    logic [DATA_W-1:0]  id_immediate;
    logic               id_alu_src;
    logic               id_reg_write;
    logic               id_mem_read;

    // Branch kill
    logic               flush;

    // Forwarding sources from later stages
    logic [RADDR_W-1:0] mem_rd_addr;
    logic               mem_reg_write;
    logic [DATA_W-1:0]  mem_result;
    logic [RADDR_W-1:0] wb_rd_addr;
    logic               wb_reg_write;
    logic [DATA_W-1:0]  wb_result;

    // Stage outputs
    logic               stall;
    logic               ex_valid;
    logic [DATA_W-1:0]  ex_rs1_data;
    logic [DATA_W-1:0]  ex_rs2_data;
    logic [DATA_W-1:0]  ex_immediate;
    logic               ex_alu_src;
    logic [RADDR_W-1:0] ex_rd_addr;
    logic               ex_reg_write;
    logic               ex_mem_read;
    logic [CNT_W-1:0]   stall_count;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data,
        output id_immediate, id_alu_src, id_reg_write, id_mem_read, flush,
        output mem_rd_addr, mem_reg_write, mem_result, wb_rd_addr, wb_reg_write, wb_result,
        input  stall, ex_valid, ex_rs1_data, ex_rs2_data, ex_immediate, ex_alu_src,
        input  ex_rd_addr, ex_reg_write, ex_mem_read, stall_count
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rs1_data, id_rs2_data,
        input  id_immediate, id_alu_src, id_reg_write, id_mem_read, flush,
        input  mem_rd_addr, mem_reg_write, mem_result, wb_rd_addr, wb_reg_write, wb_result,
        output stall, ex_valid, ex_rs1_data, ex_rs2_data, ex_immediate, ex_alu_src,
        output ex_rd_addr, ex_reg_write, ex_mem_read, stall_count
    );

endinterface

// File: rtl/mod_idex_operand_stage_fwd_sel.sv
// Forwarding selector for one EX source operand: EX/MEM beats MEM/WB beats captured value.
module mod_fwd_sel import mips_pkg::*; #(
    parameter int unsigned DATA_W  = mips_pkg::DATA_W,
    parameter int unsigned RADDR_W = mips_pkg::RADDR_W
) (
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [DATA_W-1:0]  reg_data,
    input  logic [RADDR_W-1:0] mem_rd_addr,
    input  logic               mem_reg_write,
    input  logic [DATA_W-1:0]  mem_result,
    input  logic [RADDR_W-1:0] wb_rd_addr,
    input  logic               wb_reg_write,
    input  logic [DATA_W-1:0]  wb_result,
    output fwd_sel_t           sel,
    output logic [DATA_W-1:0]  data
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_rd_addr != RADDR_W'(REG_ZERO))
                     && (mem_rd_addr == rs_addr);
    assign wb_hit  = wb_reg_write && (wb_rd_addr != RADDR_W'(REG_ZERO))
                     && (wb_rd_addr == rs_addr);

    // Priority select: the younger producer (EX/MEM) holds the newer value.
    always_comb begin
        sel = FWD_REG;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

    // Operand mux driven by the select.
    always_comb begin
        data = reg_data;
        case (sel)
            FWD_MEM: data = mem_result;
            FWD_WB:  data = wb_result;
            default: data = reg_data;
        endcase
    end

endmodule

// File: rtl/mod_idex_operand_stage.sv
// ID/EX pipeline register with load-use stall, branch flush, ID bypass and EX forwarding.
module mod_idex_operand_stage import mips_pkg::*; #(
    parameter int unsigned DATA_W  = mips_pkg::DATA_W,
    parameter int unsigned RADDR_W = mips_pkg::RADDR_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    mod_idex_operand_stage_if.slave   bus
);

    logic               ex_valid_q;
    logic [RADDR_W-1:0] ex_rs1_addr_q;
    logic [RADDR_W-1:0] ex_rs2_addr_q;
    logic [RADDR_W-1:0] ex_rd_addr_q;
    logic [DATA_W-1:0]  ex_rs1_data_q;
    logic [DATA_W-1:0]  ex_rs2_data_q;
    logic [DATA_W-1:0]  ex_immediate_q;
    logic               ex_alu_src_q;
    logic               ex_reg_write_q;
    logic               ex_mem_read_q;
    logic [CNT_W-1:0]   stall_count_q;

    logic               hz;
    logic               stall;
    logic               wb_hit_rs1;
    logic               wb_hit_rs2;
    logic [DATA_W-1:0]  cap_rs1_data;
    logic [DATA_W-1:0]  cap_rs2_data;
    fwd_sel_t           rs1_sel;
    fwd_sel_t           rs2_sel;
    logic [DATA_W-1:0]  rs1_fwd_data;
    logic [DATA_W-1:0]  rs2_fwd_data;

    // Load-use hazard: the load in EX has not produced its data yet, so ID must wait.
    always_comb begin
        hz = ex_valid_q && ex_mem_read_q && bus.id_valid
             && (ex_rd_addr_q != RADDR_W'(REG_ZERO))
             && ((ex_rd_addr_q == bus.id_rs1_addr) || (ex_rd_addr_q == bus.id_rs2_addr));
        stall = hz && !bus.flush;
    end

    // ID bypass: the regfile write happening this cycle is not yet visible to the ID read.
    always_comb begin
        wb_hit_rs1 = bus.wb_reg_write && (bus.wb_rd_addr != RADDR_W'(REG_ZERO))
                     && (bus.wb_rd_addr == bus.id_rs1_addr);
        wb_hit_rs2 = bus.wb_reg_write && (bus.wb_rd_addr != RADDR_W'(REG_ZERO))
                     && (bus.wb_rd_addr == bus.id_rs2_addr);
        cap_rs1_data = wb_hit_rs1 ? bus.wb_result : bus.id_rs1_data;
        cap_rs2_data = wb_hit_rs2 ? bus.wb_result : bus.id_rs2_data;
    end

    // Stage register: reset > flush/hazard bubble > normal capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_rs1_addr_q  <= '0;
            ex_rs2_addr_q  <= '0;
            ex_rd_addr_q   <= '0;
            ex_rs1_data_q  <= '0;
            ex_rs2_data_q  <= '0;
            ex_immediate_q <= '0;
            ex_alu_src_q   <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
        end else if (bus.flush || hz) begin
            // Bubble: only the control bits matter, data fields are left as-is.
            ex_valid_q     <= 1'b0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
        end else begin
            ex_valid_q     <= bus.id_valid;
            ex_rs1_addr_q  <= bus.id_rs1_addr;
            ex_rs2_addr_q  <= bus.id_rs2_addr;
            ex_rd_addr_q   <= bus.id_rd_addr;
            ex_rs1_data_q  <= cap_rs1_data;
            ex_rs2_data_q  <= cap_rs2_data;
            ex_immediate_q <= bus.id_immediate;
            ex_alu_src_q   <= bus.id_alu_src;
            ex_reg_write_q <= bus.id_reg_write;
            ex_mem_read_q  <= bus.id_mem_read;
        end
    end

    // Saturating stall-cycle counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_q <= '0;
        end else if (stall && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + 1'b1;
        end
    end

    mod_fwd_sel #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs1 (
        .rs_addr       (ex_rs1_addr_q),
        .reg_data      (ex_rs1_data_q),
        .mem_rd_addr   (bus.mem_rd_addr),
        .mem_reg_write (bus.mem_reg_write),
        .mem_result    (bus.mem_result),
        .wb_rd_addr    (bus.wb_rd_addr),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_result     (bus.wb_result),
        .sel           (rs1_sel),
        .data          (rs1_fwd_data)
    );

    // rs2 is forwarded even for immediate-form instructions: stores need it as write data.
    mod_fwd_sel #(
        .DATA_W  (DATA_W),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs2 (
        .rs_addr       (ex_rs2_addr_q),
        .reg_data      (ex_rs2_data_q),
        .mem_rd_addr   (bus.mem_rd_addr),
        .mem_reg_write (bus.mem_reg_write),
        .mem_result    (bus.mem_result),
        .wb_rd_addr    (bus.wb_rd_addr),
        .wb_reg_write  (bus.wb_reg_write),
        .wb_result     (bus.wb_result),
        .sel           (rs2_sel),
        .data          (rs2_fwd_data)
    );

    // A forwarding select other than the captured value must always name a real register.
    a_rs1_fwd_nonzero: assert property (@(posedge clk) disable iff (rst)
        (rs1_sel != FWD_REG) |-> (ex_rs1_addr_q != RADDR_W'(REG_ZERO)));
    a_rs2_fwd_nonzero: assert property (@(posedge clk) disable iff (rst)
        (rs2_sel != FWD_REG) |-> (ex_rs2_addr_q != RADDR_W'(REG_ZERO)));

    assign bus.stall        = stall;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_rs1_data  = rs1_fwd_data;
    assign bus.ex_rs2_data  = rs2_fwd_data;
    assign bus.ex_immediate = ex_immediate_q;
    assign bus.ex_alu_src   = ex_alu_src_q;
    assign bus.ex_rd_addr   = ex_rd_addr_q;
    assign bus.ex_reg_write = ex_reg_write_q && ex_valid_q;
    assign bus.ex_mem_read  = ex_mem_read_q && ex_valid_q;
    assign bus.stall_count  = stall_count_q;

endmodule

// File: tb/tb_mod_idex_operand_stage.sv
// Self-checking bench for the ID/EX operand stage: directed table, hazard sequences, random run.
module tb_mod_idex_operand_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;  // small counter so saturation is reachable
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mod_idex_operand_stage_if #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) bus ();

    mod_idex_operand_stage #(.DATA_W(DW), .RADDR_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: the instruction currently sitting in EX.
    bit          m_valid, m_rw, m_mr, m_src;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_d1, m_d2, m_imm;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] cap);
        if (hit(bus.mem_reg_write, bus.mem_rd_addr, rs)) return bus.mem_result;
        if (hit(bus.wb_reg_write, bus.wb_rd_addr, rs)) return bus.wb_result;
        return cap;
    endfunction

    function automatic bit model_hz();
        return m_valid && m_mr && bus.id_valid && (m_rd != 5'd0)
               && (m_rd == bus.id_rs1_addr || m_rd == bus.id_rs2_addr);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_mr = 0; m_src = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_d1 = 0; m_d2 = 0; m_imm = 0; m_cnt = 0;
    endtask

    task automatic check_all();
        chk("stall", bus.stall, model_hz() && !bus.flush);
        chk("ex_valid", bus.ex_valid, m_valid);
        chk("ex_reg_write", bus.ex_reg_write, m_valid && m_rw);
        chk("ex_mem_read", bus.ex_mem_read, m_valid && m_mr);
        chk("stall_count", bus.stall_count, m_cnt);
        if (m_valid) begin
            chk("ex_rs1_data", bus.ex_rs1_data, fwd(m_rs1, m_d1));
            chk("ex_rs2_data", bus.ex_rs2_data, fwd(m_rs2, m_d2));
            chk("ex_immediate", bus.ex_immediate, m_imm);
            chk("ex_alu_src", bus.ex_alu_src, m_src);
            chk("ex_rd_addr", bus.ex_rd_addr, m_rd);
        end
    endtask

    // Check current outputs, advance the model and the DUT by one clock.
    task automatic cycle();
        bit hz, fl;
        logic [31:0] c1, c2;
        #1;
        check_all();
        hz = model_hz();
        fl = bus.flush;
        c1 = hit(bus.wb_reg_write, bus.wb_rd_addr, bus.id_rs1_addr) ? bus.wb_result
                                                                    : bus.id_rs1_data;
        c2 = hit(bus.wb_reg_write, bus.wb_rd_addr, bus.id_rs2_addr) ? bus.wb_result
                                                                    : bus.id_rs2_data;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (hz && !fl && m_cnt < CNT_MAX) m_cnt++;
            if (hz || fl) begin
                m_valid = 0; m_rw = 0; m_mr = 0;
            end else begin
                m_valid = bus.id_valid; m_rw = bus.id_reg_write; m_mr = bus.id_mem_read;
                m_src = bus.id_alu_src; m_rs1 = bus.id_rs1_addr; m_rs2 = bus.id_rs2_addr;
                m_rd = bus.id_rd_addr; m_d1 = c1; m_d2 = c2; m_imm = bus.id_immediate;
            end
        end
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] imm, input logic src, input logic rw,
                          input logic mr);
        bus.id_valid = v; bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2; bus.id_rd_addr = rd;
        bus.id_rs1_data = d1; bus.id_rs2_data = d2; bus.id_immediate = imm;
        bus.id_alu_src = src; bus.id_reg_write = rw; bus.id_mem_read = mr;
    endtask

    task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] mres,
                           input logic wwe, input logic [4:0] wrd, input logic [31:0] wres);
        bus.mem_reg_write = mwe; bus.mem_rd_addr = mrd; bus.mem_result = mres;
        bus.wb_reg_write = wwe; bus.wb_rd_addr = wrd; bus.wb_result = wres;
    endtask

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2;
        logic        cwb_we; logic [4:0] cwb_rd; logic [31:0] cwb_res;  // during capture
        logic        mem_we; logic [4:0] mem_rd; logic [31:0] mem_res;  // while in EX
        logic        wb_we;  logic [4:0] wb_rd;  logic [31:0] wb_res;
        logic [31:0] e1, e2;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 0, 5'd0, 0, 0, 5'd0, 0, 0, 5'd0, 0,
                    32'd5, 32'd7};
        vecs[1] = '{5'd9, 5'd4, 5'd3, 32'd1, 32'h44, 0, 5'd0, 0, 1, 5'd4, 32'hAA, 1, 5'd4,
                    32'hBB, 32'd1, 32'hAA};
        vecs[2] = '{5'd9, 5'd4, 5'd3, 32'd1, 32'h44, 0, 5'd0, 0, 0, 5'd4, 32'hAA, 1, 5'd4,
                    32'hBB, 32'd1, 32'hBB};
        vecs[3] = '{5'd0, 5'd2, 5'd3, 32'd0, 32'h22, 0, 5'd0, 0, 1, 5'd0, 32'hDEAD, 1, 5'd0,
                    32'hBEEF, 32'd0, 32'h22};
        vecs[4] = '{5'd6, 5'd7, 5'd3, 32'h11, 32'h77, 1, 5'd6, 32'h55, 0, 5'd0, 0, 0, 5'd0, 0,
                    32'h55, 32'h77};
        vecs[5] = '{5'd5, 5'd5, 5'd3, 32'h1, 32'h2, 0, 5'd0, 0, 1, 5'd5, 32'h1234, 0, 5'd0, 0,
                    32'h1234, 32'h1234};
        vecs[6] = '{5'd10, 5'd11, 5'd3, 32'h3, 32'h4, 0, 5'd0, 0, 1, 5'd12, 32'h66, 1, 5'd10,
                    32'h99, 32'h99, 32'h4};

        // Reset for two cycles
        rst = 1'b1;
        bus.flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_rs1", bus.ex_rs1_data, 0);
        chk("rst_rs2", bus.ex_rs2_data, 0);
        chk("rst_imm", bus.ex_immediate, 0);
        chk("rst_rd", bus.ex_rd_addr, 0);
        chk("rst_rw", bus.ex_reg_write, 0);
        chk("rst_mr", bus.ex_mem_read, 0);
        chk("rst_stall", bus.stall, 0);
        chk("rst_count", bus.stall_count, 0);
        rst = 1'b0;

        // Directed forwarding/bypass table
        for (int i = 0; i < 7; i++) begin
            set_id(1, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].d1, vecs[i].d2,
                   32'h100 + i, i[0], 1, 0);
            set_fwd(0, 0, 0, vecs[i].cwb_we, vecs[i].cwb_rd, vecs[i].cwb_res);
            cycle();
            set_fwd(vecs[i].mem_we, vecs[i].mem_rd, vecs[i].mem_res,
                    vecs[i].wb_we, vecs[i].wb_rd, vecs[i].wb_res);
            #1;
            chk($sformatf("tbl%0d_rs1", i), bus.ex_rs1_data, vecs[i].e1);
            chk($sformatf("tbl%0d_rs2", i), bus.ex_rs2_data, vecs[i].e2);
            chk($sformatf("tbl%0d_valid", i), bus.ex_valid, 1);
        end
        set_fwd(0, 0, 0, 0, 0, 0);

        // Load-use stall: one stall, one bubble, then normal entry
        set_id(1, 0, 0, 8, 0, 0, 0, 1, 1, 1);
        cycle();
        set_id(1, 1, 8, 9, 32'h10, 32'h20, 0, 0, 1, 0);
        #1;
        chk("lu_stall", bus.stall, 1);
        cycle();
        chk("lu_bubble", bus.ex_valid, 0);
        chk("lu_count", bus.stall_count, 1);
        chk("lu_stall_drop", bus.stall, 0);
        cycle();
        chk("lu_enter", bus.ex_valid, 1);
        chk("lu_rd", bus.ex_rd_addr, 9);

        // Same hazard with flush: no stall, bubble, counter unchanged
        set_id(1, 0, 0, 8, 0, 0, 0, 1, 1, 1);
        cycle();
        set_id(1, 8, 3, 10, 0, 0, 0, 0, 1, 0);
        bus.flush = 1'b1;
        #1;
        chk("fl_stall", bus.stall, 0);
        cycle();
        bus.flush = 1'b0;
        chk("fl_bubble", bus.ex_valid, 0);
        chk("fl_count", bus.stall_count, 1);

        // Reset asserted while stalled
        set_id(1, 0, 0, 8, 0, 0, 0, 1, 1, 1);
        cycle();
        set_id(1, 8, 8, 10, 0, 0, 0, 0, 1, 0);
        #1;
        chk("rs_stall", bus.stall, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("rs_valid", bus.ex_valid, 0);
        chk("rs_stall_drop", bus.stall, 0);
        chk("rs_count", bus.stall_count, 0);

        // Saturation of the stall counter
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            set_id(1, 0, 0, 8, 0, 0, 0, 1, 1, 1);
            cycle();
            set_id(1, 2, 8, 4, 0, 0, 0, 0, 1, 0);
            cycle();
        end
        chk("sat_count", bus.stall_count, CNT_MAX);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(63) == 0);
            bus.flush = ($urandom_range(7) == 0);
            set_id($urandom_range(3) != 0, 5'($urandom_range(7)), 5'($urandom_range(7)),
                   5'($urandom_range(7)), $urandom, $urandom, $urandom, 1'($urandom),
                   1'($urandom), $urandom_range(2) == 0);
            set_fwd(1'($urandom), 5'($urandom_range(7)), $urandom,
                    1'($urandom), 5'($urandom_range(7)), $urandom);
            cycle();
        end
        rst = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
